// File: rtl/result_pack.sv
// Result packer: gathers 16-bit PE results (quad or serial) into 64-bit words and
// writes them to the result RAM over a valid/ready port, flushing partial words on done.
module result_pack #(
   parameter int ADDR_W = 12
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              start_pos,
   input  logic              done,
   input  logic [1:0]        mode,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [15:0]       res_0,
   input  logic [15:0]       res_1,
   input  logic [15:0]       res_2,
   input  logic [15:0]       res_3,
   output logic              wr_valid,
   input  logic              wr_ready,
   output logic [63:0]       wr_data,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [7:0]        wr_strb,
   output logic              busy,
   output logic              flush_done,
   output logic [1:0]        dbg_state
);

   // Handshakes: a beat transfers on a rising clk edge where in_valid && in_ready;
   // a word transfers on a rising clk edge where wr_valid && wr_ready. Once raised,
   // wr_valid holds with wr_data/wr_addr/wr_strb stable until the transfer.

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PACK  = 2'd1,
      ST_FLUSH = 2'd2,
      ST_DRAIN = 2'd3
   } state_t;

   localparam logic [1:0] MODE_S16 = 2'b01;
   localparam logic [1:0] MODE_S8  = 2'b10;

   state_t              state_q, state_d;
   logic [1:0]          mode_q, mode_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [63:0]         acc_q, acc_d;
   logic [2:0]          cnt_q, cnt_d;
   logic                wr_valid_q, wr_valid_d;
   logic [63:0]         wr_data_q, wr_data_d;
   logic [7:0]          wr_strb_q, wr_strb_d;
   logic                flush_done_q, flush_done_d;

   logic [63:0]         beat_word;
   logic                completes;
   logic [2:0]          fill_bytes;
   logic [7:0]          part_strb;
   logic                accept;
   logic                wr_fire;

   // Merge the incoming beat into the accumulator at the slot selected by cnt.
   always_comb begin
      beat_word = acc_q;
      completes = 1'b0;
      case (mode_q)
         MODE_S16: begin
            beat_word[{cnt_q[1:0], 4'b0000} +: 16] = res_0;
            completes = (cnt_q[1:0] == 2'd3);
         end
         MODE_S8: begin
            beat_word[{cnt_q, 3'b000} +: 8] = res_0[7:0];
            completes = (cnt_q == 3'd7);
         end
         default: begin
            beat_word = {res_3, res_2, res_1, res_0};
            completes = 1'b1;
         end
      endcase
   end

   // Bytes already filled in a partial word; quad16 never leaves a partial word.
   always_comb begin
      fill_bytes = 3'd0;
      case (mode_q)
         MODE_S16: fill_bytes = {cnt_q[1:0], 1'b0};
         MODE_S8:  fill_bytes = cnt_q;
         default:  fill_bytes = 3'd0;
      endcase
      part_strb = ~(8'hFF << fill_bytes);
   end

   assign in_ready = (state_q == ST_PACK) && (!completes || !wr_valid_q || wr_ready);
   assign accept   = in_valid && in_ready;
   assign wr_fire  = wr_valid_q && wr_ready;

   always_comb begin
      state_d      = state_q;
      mode_d       = mode_q;
      addr_d       = addr_q;
      acc_d        = acc_q;
      cnt_d        = cnt_q;
      wr_valid_d   = wr_valid_q;
      wr_data_d    = wr_data_q;
      wr_strb_d    = wr_strb_q;
      flush_done_d = 1'b0;

      // An accepted word frees the output register and advances the address.
      if (wr_fire) begin
         wr_valid_d = 1'b0;
         addr_d     = addr_q + 1'b1;
      end

      case (state_q)
         ST_IDLE: begin
            state_d = ST_IDLE;
         end
         ST_PACK: begin
            if (accept) begin
               if (completes) begin
                  wr_data_d  = beat_word;
                  wr_strb_d  = 8'hFF;
                  wr_valid_d = 1'b1;
                  acc_d      = 64'd0;
                  cnt_d      = 3'd0;
               end else begin
                  acc_d = beat_word;
                  cnt_d = cnt_q + 3'd1;
               end
            end
            if (done) begin
               state_d = ST_FLUSH;
            end
         end
         ST_FLUSH: begin
            if (cnt_q == 3'd0) begin
               state_d = ST_DRAIN;
            end else if (!wr_valid_q || wr_ready) begin
               wr_data_d  = acc_q;
               wr_strb_d  = part_strb;
               wr_valid_d = 1'b1;
               acc_d      = 64'd0;
               cnt_d      = 3'd0;
               state_d    = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (!wr_valid_q) begin
               flush_done_d = 1'b1;
               state_d      = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // A new operation overrides everything, including a pending word or flush.
      if (start_pos) begin
         state_d      = ST_PACK;
         mode_d       = mode;
         addr_d       = base_addr;
         acc_d        = 64'd0;
         cnt_d        = 3'd0;
         wr_valid_d   = 1'b0;
         flush_done_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q      <= ST_IDLE;
         mode_q       <= 2'b00;
         addr_q       <= '0;
         acc_q        <= 64'd0;
         cnt_q        <= 3'd0;
         wr_valid_q   <= 1'b0;
         wr_data_q    <= 64'd0;
         wr_strb_q    <= 8'd0;
         flush_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         mode_q       <= mode_d;
         addr_q       <= addr_d;
         acc_q        <= acc_d;
         cnt_q        <= cnt_d;
         wr_valid_q   <= wr_valid_d;
         wr_data_q    <= wr_data_d;
         wr_strb_q    <= wr_strb_d;
         flush_done_q <= flush_done_d;
      end
   end

   assign wr_valid   = wr_valid_q;
   assign wr_data    = wr_data_q;
   assign wr_addr    = addr_q;
   assign wr_strb    = wr_strb_q;
   assign busy       = (state_q != ST_IDLE);
   assign flush_done = flush_done_q;
   assign dbg_state  = state_q;

endmodule

// File: tb/tb_result_pack.sv
// Directed bench for result_pack: hand-computed words per mode, address wrap,
// backpressure, flush of partial words, start/done override and async reset.
module tb_result_pack;

   localparam int ADDR_W = 12;

   logic              clk;
   logic              rstn;
   logic              start_pos;
   logic              done;
   logic [1:0]        mode;
   logic [ADDR_W-1:0] base_addr;
   logic              in_valid;
   logic              in_ready;
   logic [15:0]       res_0, res_1, res_2, res_3;
   logic              wr_valid;
   logic              wr_ready;
   logic [63:0]       wr_data;
   logic [ADDR_W-1:0] wr_addr;
   logic [7:0]        wr_strb;
   logic              busy;
   logic              flush_done;
   logic [1:0]        dbg_state;

   int n_checks = 0;
   int n_errors = 0;

   // Expected writes: {addr, strb, data}
   logic [83:0] exp_q[$];
   logic [83:0] mon_e;

   result_pack #(.ADDR_W(ADDR_W)) dut (
      .clk        (clk),
      .rstn       (rstn),
      .start_pos  (start_pos),
      .done       (done),
      .mode       (mode),
      .base_addr  (base_addr),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .res_0      (res_0),
      .res_1      (res_1),
      .res_2      (res_2),
      .res_3      (res_3),
      .wr_valid   (wr_valid),
      .wr_ready   (wr_ready),
      .wr_data    (wr_data),
      .wr_addr    (wr_addr),
      .wr_strb    (wr_strb),
      .busy       (busy),
      .flush_done (flush_done),
      .dbg_state  (dbg_state)
   );

   // Clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Scoreboard: every accepted write must match the head of exp_q.
   always @(negedge clk) begin
      if (rstn && wr_valid && wr_ready) begin
         check_eq("wr_expected", 64'(exp_q.size() != 0), 64'd1);
         if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            check_eq("wr_addr", 64'(wr_addr), 64'(mon_e[83:72]));
            check_eq("wr_strb", 64'(wr_strb), 64'(mon_e[71:64]));
            check_eq("wr_data", wr_data, mon_e[63:0]);
         end
      end
   end

   // Driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_word(input logic [ADDR_W-1:0] a, input logic [7:0] s, input logic [63:0] d);
      exp_q.push_back({a, s, d});
   endtask

   task automatic start_op(input logic [1:0] m, input logic [ADDR_W-1:0] b);
      start_pos = 1'b1;
      mode      = m;
      base_addr = b;
      tick();
      start_pos = 1'b0;
   endtask

   task automatic send_beat(input logic [15:0] r0, input logic [15:0] r1,
                            input logic [15:0] r2, input logic [15:0] r3,
                            input logic with_done, output int waited);
      in_valid = 1'b1;
      res_0 = r0; res_1 = r1; res_2 = r2; res_3 = r3;
      waited = 0;
      while (1) begin
         @(negedge clk);
         if (in_ready) begin
            done = with_done;
            break;
         end
         waited++;
         if (waited > 50) begin
            check_eq("beat_timeout", 64'(in_ready), 64'd1);
            break;
         end
      end
      tick();
      in_valid = 1'b0;
      done     = 1'b0;
   endtask

   task automatic pulse_done();
      done = 1'b1;
      tick();
      done = 1'b0;
   endtask

   task automatic wait_flush();
      logic found;
      found = 1'b0;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (flush_done) begin
            found = 1'b1;
            break;
         end
      end
      check_eq("flush_done_seen", 64'(found), 64'd1);
      @(negedge clk);
      check_eq("flush_done_pulse", 64'(flush_done), 64'd0);
      check_eq("idle_after_flush", 64'(busy), 64'd0);
      check_eq("all_words_written", 64'(exp_q.size()), 64'd0);
      tick();
   endtask

   initial begin
      int w;
      logic fd_exp [4];
      fd_exp = '{1'b0, 1'b0, 1'b1, 1'b0};

      rstn = 1'b0; start_pos = 1'b0; done = 1'b0; mode = 2'b00; base_addr = '0;
      in_valid = 1'b0; wr_ready = 1'b0;
      res_0 = 16'h0; res_1 = 16'h0; res_2 = 16'h0; res_3 = 16'h0;

      // Reset state
      repeat (2) @(negedge clk);
      check_eq("rst_in_ready", 64'(in_ready), 64'd0);
      check_eq("rst_wr_valid", 64'(wr_valid), 64'd0);
      check_eq("rst_busy", 64'(busy), 64'd0);
      check_eq("rst_flush_done", 64'(flush_done), 64'd0);
      check_eq("rst_wr_data", wr_data, 64'd0);
      check_eq("rst_wr_addr", 64'(wr_addr), 64'd0);
      check_eq("rst_wr_strb", 64'(wr_strb), 64'd0);
      tick();
      rstn = 1'b1;
      tick();

      // quad16, full throughput, 3 words
      wr_ready = 1'b1;
      start_op(2'b00, 12'h010);
      expect_word(12'h010, 8'hFF, 64'h0004_0003_0002_0001);
      expect_word(12'h011, 8'hFF, 64'h0005_0004_0003_0002);
      expect_word(12'h012, 8'hFF, 64'h0006_0005_0004_0003);
      for (int n = 0; n < 3; n++) begin
         send_beat(16'(1 + n), 16'(2 + n), 16'(3 + n), 16'(4 + n), 1'b0, w);
         check_eq("q16_no_stall", 64'(w), 64'd0);
      end
      pulse_done();
      wait_flush();

      // serial16, 6 beats, done with last beat -> partial word strb 0F
      start_op(2'b01, 12'h020);
      expect_word(12'h020, 8'hFF, 64'h00A3_00A2_00A1_00A0);
      expect_word(12'h021, 8'h0F, 64'h0000_0000_00A5_00A4);
      for (int n = 0; n < 6; n++) begin
         send_beat(16'(16'h00A0 + n), 16'hDEAD, 16'hBEEF, 16'hCAFE, (n == 5), w);
      end
      wait_flush();

      // serial8 with backpressure
      wr_ready = 1'b0;
      start_op(2'b10, 12'h030);
      expect_word(12'h030, 8'hFF, 64'h8877_6655_4433_2211);
      expect_word(12'h031, 8'hFF, 64'h0807_0605_0403_0201);
      for (int n = 1; n <= 8; n++) begin
         send_beat({8'hC3, 8'(8'h11 * n)}, 16'h0, 16'h0, 16'h0, 1'b0, w);
      end
      for (int n = 0; n < 5; n++) begin
         @(negedge clk);
         check_eq("s8_hold_valid", 64'(wr_valid), 64'd1);
         check_eq("s8_hold_data", wr_data, 64'h8877_6655_4433_2211);
      end
      tick();
      for (int n = 1; n <= 7; n++) begin
         send_beat({8'h5A, 8'(n)}, 16'h0, 16'h0, 16'h0, 1'b0, w);
      end
      in_valid = 1'b1;
      res_0 = {8'h5A, 8'h08};
      @(negedge clk);
      check_eq("s8_16th_blocked", 64'(in_ready), 64'd0);
      tick();
      @(negedge clk);
      check_eq("s8_16th_still_blocked", 64'(in_ready), 64'd0);
      check_eq("s8_still_valid", 64'(wr_valid), 64'd1);
      tick();
      wr_ready = 1'b1;
      @(negedge clk);
      check_eq("s8_16th_released", 64'(in_ready), 64'd1);
      tick();
      in_valid = 1'b0;
      pulse_done();
      wait_flush();

      // Address wrap, mode 11 behaves as quad16
      start_op(2'b11, 12'hFFF);
      expect_word(12'hFFF, 8'hFF, 64'h4444_3333_2222_1111);
      expect_word(12'h000, 8'hFF, 64'hDDDD_CCCC_BBBB_AAAA);
      send_beat(16'h1111, 16'h2222, 16'h3333, 16'h4444, 1'b0, w);
      send_beat(16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD, 1'b0, w);
      pulse_done();
      wait_flush();

      // start_pos together with done while a partial word is pending
      start_op(2'b01, 12'h100);
      send_beat(16'h0B01, 16'h0, 16'h0, 16'h0, 1'b0, w);
      send_beat(16'h0B02, 16'h0, 16'h0, 16'h0, 1'b0, w);
      start_pos = 1'b1; done = 1'b1; mode = 2'b00; base_addr = 12'h200;
      tick();
      start_pos = 1'b0; done = 1'b0; mode = 2'b01;
      @(negedge clk);
      check_eq("restart_wr_valid", 64'(wr_valid), 64'd0);
      check_eq("restart_addr", 64'(wr_addr), 64'h200);
      check_eq("restart_busy", 64'(busy), 64'd1);
      for (int n = 0; n < 4; n++) begin
         check_eq("restart_no_flush_done", 64'(flush_done), 64'd0);
         @(negedge clk);
      end
      tick();
      expect_word(12'h200, 8'hFF, 64'h0044_0033_0022_0011);
      send_beat(16'h0011, 16'h0022, 16'h0033, 16'h0044, 1'b0, w);
      pulse_done();
      wait_flush();

      // done with nothing pending: flush_done exactly 2 cycles later
      start_op(2'b00, 12'h300);
      done = 1'b1;
      @(posedge clk);
      #1;
      done = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check_eq("empty_done_fd", 64'(flush_done), 64'(fd_exp[k]));
      end
      check_eq("empty_done_no_write", 64'(exp_q.size()), 64'd0);
      tick();

      // done in IDLE ignored
      pulse_done();
      @(negedge clk);
      check_eq("idle_done_busy", 64'(busy), 64'd0);
      @(negedge clk);
      check_eq("idle_done_fd", 64'(flush_done), 64'd0);
      tick();

      // Async reset with a pending word
      wr_ready = 1'b0;
      start_op(2'b00, 12'h0AA);
      send_beat(16'h0001, 16'h0002, 16'h0003, 16'h0004, 1'b0, w);
      @(negedge clk);
      check_eq("pre_rst_valid", 64'(wr_valid), 64'd1);
      check_eq("pre_rst_addr", 64'(wr_addr), 64'h0AA);
      @(posedge clk);
      #2;
      rstn = 1'b0;
      #1;
      check_eq("arst_wr_valid", 64'(wr_valid), 64'd0);
      check_eq("arst_busy", 64'(busy), 64'd0);
      check_eq("arst_wr_data", wr_data, 64'd0);
      check_eq("arst_wr_addr", 64'(wr_addr), 64'd0);
      check_eq("arst_wr_strb", 64'(wr_strb), 64'd0);
      check_eq("arst_in_ready", 64'(in_ready), 64'd0);
      tick();
      rstn = 1'b1;
      tick();
      check_eq("final_no_pending", 64'(exp_q.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
